// File: rtl/mul_err_sweep_ctrl.sv
// mul_err_sweep_ctrl: walks every operand pair of an approximate multiplier,
// compares its product against an exact product computed locally, and
// accumulates total, count and worst-case absolute error.
module mul_err_sweep_ctrl #(
  parameter int OPW = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic [OPW-1:0]     op_a,
  output logic [OPW-1:0]     op_b,
  input  logic [2*OPW-1:0]   approx_p,
  output logic               busy,
  output logic               done,
  output logic [31:0]        sum_abs_err,
  output logic [2*OPW:0]     err_count,
  output logic [2*OPW-1:0]   max_err,
  output logic [OPW-1:0]     worst_a,
  output logic [OPW-1:0]     worst_b
);

  localparam int KW = 2 * OPW;
  localparam logic [KW-1:0] K_ZERO = {KW{1'b0}};
  localparam logic [KW-1:0] K_ONE  = {{(KW-1){1'b0}}, 1'b1};
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [KW:0]   CNT_ONE = {{KW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Unsigned magnitude of the difference of two products.
  function automatic logic [KW-1:0] abs_diff(input logic [KW-1:0] x,
                                             input logic [KW-1:0] y);
    logic [KW-1:0] r;
    if (x >= y) begin
      r = x - y;
    end else begin
      r = y - x;
    end
    return r;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [KW-1:0]   k_r, k_nxt_s;
  logic            clear_s, load_pipe_s, acc_en_s;
  logic            busy_r, done_r;

  logic            pipe_valid_r;
  logic [KW-1:0]   pipe_exact_r, pipe_approx_r;
  logic [OPW-1:0]  pipe_a_r, pipe_b_r;

  logic [31:0]     sum_r;
  logic [KW:0]     cnt_r;
  logic [KW-1:0]   max_r;
  logic [OPW-1:0]  worst_a_r, worst_b_r;

  logic [KW-1:0]   exact_s;
  logic [KW-1:0]   abs_err_s;

  // k is held at zero outside RUN, so the operands fall to zero in every
  // other state without a separate mux.
  assign op_a        = k_r[KW-1:OPW];
  assign op_b        = k_r[OPW-1:0];
  assign busy        = busy_r;
  assign done        = done_r;
  assign sum_abs_err = sum_r;
  assign err_count   = cnt_r;
  assign max_err     = max_r;
  assign worst_a     = worst_a_r;
  assign worst_b     = worst_b_r;

  assign exact_s   = {{OPW{1'b0}}, k_r[KW-1:OPW]} * {{OPW{1'b0}}, k_r[OPW-1:0]};
  assign abs_err_s = abs_diff(pipe_exact_r, pipe_approx_r);

  // Next-state, next-index and stage enables; abort outranks start while busy.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    clear_s     = 1'b0;
    load_pipe_s = 1'b0;
    acc_en_s    = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        k_nxt_s = K_ZERO;
        if (start) begin
          state_nxt_s = ST_RUN;
          clear_s     = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
          k_nxt_s     = K_ZERO;
        end else begin
          load_pipe_s = 1'b1;
          acc_en_s    = pipe_valid_r;
          if (k_r == K_LAST) begin
            state_nxt_s = ST_DRAIN;
            k_nxt_s     = K_ZERO;
          end else begin
            state_nxt_s = ST_RUN;
            k_nxt_s     = k_r + K_ONE;
          end
        end
      end
      ST_DRAIN: begin
        k_nxt_s = K_ZERO;
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
          acc_en_s    = pipe_valid_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        k_nxt_s     = K_ZERO;
      end
    endcase
  end

  // State, pair index and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      k_r     <= K_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      k_r     <= k_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Single pipeline stage capturing both products of the presented pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_valid_r  <= 1'b0;
      pipe_exact_r  <= K_ZERO;
      pipe_approx_r <= K_ZERO;
      pipe_a_r      <= {OPW{1'b0}};
      pipe_b_r      <= {OPW{1'b0}};
    end else if (load_pipe_s) begin
      pipe_valid_r  <= 1'b1;
      pipe_exact_r  <= exact_s;
      pipe_approx_r <= approx_p;
      pipe_a_r      <= k_r[KW-1:OPW];
      pipe_b_r      <= k_r[OPW-1:0];
    end else begin
      pipe_valid_r  <= 1'b0;
    end
  end

  // Error metrics: cleared on an accepted start, frozen whenever not accumulating.
  always_ff @(posedge clk) begin
    if (rst || clear_s) begin
      sum_r     <= 32'd0;
      cnt_r     <= {(KW+1){1'b0}};
      max_r     <= K_ZERO;
      worst_a_r <= {OPW{1'b0}};
      worst_b_r <= {OPW{1'b0}};
    end else if (acc_en_s) begin
      sum_r <= sum_r + {{(32-KW){1'b0}}, abs_err_s};
      if (abs_err_s != K_ZERO) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      // Strictly greater keeps the first pair that reached the maximum.
      if (abs_err_s > max_r) begin
        max_r     <= abs_err_s;
        worst_a_r <= pipe_a_r;
        worst_b_r <= pipe_b_r;
      end else begin
        max_r     <= max_r;
        worst_a_r <= worst_a_r;
        worst_b_r <= worst_b_r;
      end
    end else begin
      sum_r     <= sum_r;
      cnt_r     <= cnt_r;
      max_r     <= max_r;
      worst_a_r <= worst_a_r;
      worst_b_r <= worst_b_r;
    end
  end

endmodule

// File: tb/tb_mul_err_sweep_ctrl.sv
// tb_mul_err_sweep_ctrl: directed sequence against mul_err_sweep_ctrl with a
// selectable approximate-multiplier model and a pair-by-pair reference model.
module tb_mul_err_sweep_ctrl;

  localparam int M_EXACT = 0;
  localparam int M_ZERO  = 1;
  localparam int M_PLUS1 = 2;
  localparam int M_RAND  = 3;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [7:0]  op_a, op_b;
  logic [15:0] approx_p;
  logic        busy, done;
  logic [31:0] sum_abs_err;
  logic [16:0] err_count;
  logic [15:0] max_err;
  logic [7:0]  worst_a, worst_b;

  int          mode;
  logic [7:0]  rnd_tab [256];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  mul_err_sweep_ctrl #(.OPW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .op_a(op_a), .op_b(op_b), .approx_p(approx_p),
    .busy(busy), .done(done), .sum_abs_err(sum_abs_err),
    .err_count(err_count), .max_err(max_err),
    .worst_a(worst_a), .worst_b(worst_b)
  );

  always #5 clk = ~clk;

  // Approximate multiplier behaviour for each test mode.
  function automatic logic [15:0] approx_of(input logic [7:0] a, input logic [7:0] b,
                                            input int m, input logic [7:0] ra,
                                            input logic [7:0] rb);
    logic [15:0] ex;
    ex = 16'(a) * 16'(b);
    case (m)
      M_EXACT: return ex;
      M_ZERO:  return 16'h0000;
      M_PLUS1: return ex + 16'd1;
      M_RAND:  return ex ^ {ra, rb};
      default: return ex;
    endcase
  endfunction

  // Combinational product seen by the DUT.
  always_comb approx_p = approx_of(op_a, op_b, mode, rnd_tab[op_a ^ op_b], rnd_tab[op_b]);

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: metrics over the first npairs pairs in sweep order.
  task automatic model(input int npairs, output longint s, output longint c,
                       output longint mx, output longint wa, output longint wb);
    logic [7:0]  a, b;
    logic [15:0] ap;
    int          ex, d;
    s = 0; c = 0; mx = 0; wa = 0; wb = 0;
    for (int k = 0; k < npairs; k++) begin
      a  = 8'(k / 256);
      b  = 8'(k % 256);
      ex = int'(a) * int'(b);
      ap = approx_of(a, b, mode, rnd_tab[a ^ b], rnd_tab[b]);
      d  = ex - int'(ap);
      if (d < 0) d = -d;
      s += d;
      if (d != 0) c++;
      if (d > mx) begin
        mx = d; wa = a; wb = b;
      end
    end
  endtask

  task automatic check_metrics(input string pfx, input int npairs);
    longint s, c, mx, wa, wb;
    model(npairs, s, c, mx, wa, wb);
    chk({pfx, "_sum"}, sum_abs_err, s);
    chk({pfx, "_cnt"}, err_count, c);
    chk({pfx, "_max"}, max_err, mx);
    chk({pfx, "_wa"}, worst_a, wa);
    chk({pfx, "_wb"}, worst_b, wb);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_opa"}, op_a, 0);
    chk({pfx, "_opb"}, op_b, 0);
    chk({pfx, "_sum"}, sum_abs_err, 0);
    chk({pfx, "_cnt"}, err_count, 0);
    chk({pfx, "_max"}, max_err, 0);
    chk({pfx, "_wa"}, worst_a, 0);
    chk({pfx, "_wb"}, worst_b, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_tab[i] = 8'h00;
      else rnd_tab[i] = 8'($urandom);
    end
    mode  = M_EXACT;
    rst   = 1'b1;
    start = 1'b1;
    abort = 1'b0;

    // Reset state, reset outranking start.
    tick(); tick();
    check_zero("rst");
    rst = 1'b0; start = 1'b0;
    tick();

    // Exact multiplier: no error accumulates; abort at 400.
    mode = M_EXACT;
    do_start();
    chk("ex_busy1", busy, 1);
    chk("ex_done1", done, 0);
    chk("ex_opa1", op_a, 0);
    chk("ex_opb1", op_b, 0);
    run_to(400);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("ex_ab_busy", busy, 0);
    check_metrics("ex_ab", 398);

    // Random errors; start and abort together in IDLE: start wins.
    mode = M_RAND;
    start = 1'b1; abort = 1'b1; cyc = 0;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_idle_busy", busy, 1);
    run_to(300);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("rnd_ab_busy", busy, 0);
    chk("rnd_ab_done", done, 0);
    chk("rnd_ab_opa", op_a, 0);
    check_metrics("rnd_ab", 298);

    // Full sweep with zero product, stray start mid-sweep.
    mode = M_ZERO;
    do_start();
    chk("full_busy1", busy, 1);
    chk("full_sum1", sum_abs_err, 0);
    run_to(1000);
    chk("full_opa999", op_a, 3);
    chk("full_opb999", op_b, 231);
    start = 1'b1; tick(); start = 1'b0;
    chk("full_busy1001", busy, 1);
    chk("full_opa1000", op_a, 3);
    chk("full_opb1000", op_b, 232);
    run_to(65536);
    chk("full_opa_last", op_a, 255);
    chk("full_opb_last", op_b, 255);
    run_to(65537);
    chk("drain_busy", busy, 1);
    chk("drain_done", done, 0);
    run_to(65538);
    chk("done_busy", busy, 0);
    chk("done_done", done, 1);
    chk("done_sum", sum_abs_err, 1065369600);
    chk("done_cnt", err_count, 65025);
    chk("done_max", max_err, 65025);
    chk("done_wa", worst_a, 255);
    chk("done_wb", worst_b, 255);
    chk("done_opa", op_a, 0);
    chk("done_opb", op_b, 0);
    run_to(65541);
    chk("hold_done", done, 1);
    chk("hold_sum", sum_abs_err, 1065369600);
    chk("hold_max", max_err, 65025);

    // Restart from DONE with exact+1; abort+start while busy: abort wins.
    mode = M_PLUS1;
    do_start();
    chk("re_done", done, 0);
    chk("re_busy", busy, 1);
    chk("re_sum", sum_abs_err, 0);
    chk("re_max", max_err, 0);
    chk("re_opb", op_b, 0);
    run_to(500);
    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    chk("sa_busy_busy", busy, 0);
    chk("sa_busy_done", done, 0);
    check_metrics("p1_ab", 498);
    chk("p1_sum_const", sum_abs_err, 498);
    chk("p1_max_const", max_err, 1);

    // Reset mid-sweep clears everything, no done afterwards.
    mode = M_RAND;
    do_start();
    run_to(5000);
    rst = 1'b1; tick(); rst = 1'b0;
    check_zero("mid_rst");
    tick(); tick(); tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    // Fresh start after reset restarts from pair 0.
    mode = M_ZERO;
    do_start();
    run_to(700);
    abort = 1'b1; tick(); abort = 1'b0;
    check_metrics("fresh", 698);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_err_sweep_ctrl.md
MUL_ERR_SWEEP_CTRL -- requirements
Module: mul_err_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter OPW, default 8: operand width of the multiplier under test; only 8 is supported.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1: one-cycle request to begin a sweep.
REQ-005 The block SHALL have port abort, input, 1: terminates a sweep in progress.
REQ-006 The block SHALL have port op_a, output, 8: operand driven to the IN1 port of the approximate multiplier.
REQ-007 The block SHALL have port op_b, output, 8: operand driven to the IN2 port of the approximate multiplier.
REQ-008 The block SHALL have port approx_p, input, 16: combinational product returned by the approximate multiplier.
REQ-009 The block SHALL have port busy, output, 1: sweep in progress.
REQ-010 The block SHALL have port done, output, 1: sweep completed; metrics are valid.
REQ-011 The block SHALL have port sum_abs_err, output, 32: sum of |exact - approx| over all pairs.
REQ-012 The block SHALL have port err_count, output, 17: number of pairs with a nonzero error.
REQ-013 The block SHALL have port max_err, output, 16: worst-case absolute error.
REQ-014 The block SHALL have ports worst_a and worst_b, output, 8 each: the first operand pair that reached max_err.

Function
REQ-015 The FSM SHALL have the states IDLE, RUN, DRAIN and DONE.
REQ-016 In IDLE or DONE, start=1 SHALL move the FSM to RUN, clear all metrics and clear done.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 In RUN, a 16-bit pair index k SHALL drive op_a = k[15:8] and op_b = k[7:0]. k starts at 0 and increments by 1 each cycle, with op_b varying fastest.
REQ-019 Each RUN cycle, the block SHALL register approx_p and the internally computed exact product op_a*op_b (16 bits) into a single pipeline stage with a valid flag.
REQ-020 The accumulate stage SHALL add |exact - approx| as an unsigned 16-bit magnitude to sum_abs_err. Wrap cannot occur, because the maximum possible total is below 2^32.
REQ-021 The accumulate stage SHALL increment err_count when the absolute error is nonzero.
REQ-022 When the absolute error is strictly greater than max_err, the accumulate stage SHALL update max_err, worst_a and worst_b. On ties, the first occurrence is kept.
REQ-023 After the pair k=65535 is presented, the FSM SHALL go to DRAIN for exactly one cycle to accumulate the final pair, then go to DONE. The index k SHALL NOT wrap into a second pass.
REQ-024 Timing SHALL be as follows, where start is sampled at edge 0:
  - busy=1 from cycle 1 through cycle 65537.
  - done=1 from cycle 65538 and held until the next accepted start or reset.
REQ-025 In DONE, the metrics SHALL hold stable.
REQ-026 In IDLE and DONE, op_a and op_b SHALL be 0.
REQ-027 abort=1 in RUN or DRAIN SHALL move the FSM to IDLE on the next edge with busy=0 and done=0.
  - Metrics SHALL retain the partial values.
  - The pair in the pipeline stage SHALL be discarded.
REQ-028 If abort and start are both 1 in the same cycle while busy=1, abort SHALL win. If both are 1 in IDLE or DONE, start SHALL win.
REQ-029 The pipeline valid flag SHALL be 0 in all states except RUN and DRAIN, so no accumulation occurs outside a sweep.

Reset
REQ-030 rst=1 SHALL have priority over start and abort in any state.
REQ-031 rst=1 SHALL put the FSM in IDLE and set k=0 and the valid flag to 0.
REQ-032 rst=1 SHALL set busy=0, done=0, op_a=0, op_b=0, sum_abs_err=0, err_count=0, max_err=0, worst_a=0 and worst_b=0.
REQ-033 rst=1 asserted during RUN SHALL abandon the sweep with no done pulse.

Verification
REQ-034 Exact multiplier model on approx_p, then start -> done at cycle 65538; sum_abs_err=0, err_count=0, max_err=0, worst_a=0, worst_b=0.
REQ-035 approx_p tied to 0 -> sum_abs_err=1065369600, err_count=65025, max_err=65025, worst_a=255, worst_b=255.
REQ-036 approx_p = exact+1 -> sum_abs_err=65536, err_count=65536, max_err=1, worst_a=0, worst_b=0 (first occurrence kept).
REQ-037 abort at cycle 300 after start -> IDLE next cycle with busy=0, done=0; partial metrics retained. A following start restarts from k=0 with metrics cleared.
REQ-038 start pulsed at cycle 1000 of a sweep -> ignored; done still at cycle 65538 with unchanged results.
REQ-039 rst pulsed at cycle 5000 of a sweep -> all outputs 0 on the next cycle. A fresh start then reproduces the REQ-035 results.
